// File: rtl/uart_key_checker_if.sv
// Pad-side signal bundle of the UART key checker.
// The master drives the serial line; the slave returns LEDs, status and debug.
interface uart_key_checker_if;
    logic       uart_rx;
    logic       led_green;
    logic       led_red;
    logic       locked;
    logic [3:0] fail_count;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        output uart_rx,
        input  led_green,
        input  led_red,
        input  locked,
        input  fail_count,
        input  rx_data,
        input  rx_valid
    );

    modport slave (
        input  uart_rx,
        output led_green,
        output led_red,
        output locked,
        output fail_count,
        output rx_data,
        output rx_valid
    );
endinterface

// File: rtl/uart_key_checker.sv
// 8N1 UART receiver feeding a KEY_LEN-byte key comparator with
// green/red LED result, retry counting and permanent lockout.
module uart_key_checker #(
    parameter int unsigned           CLK_HZ      = 10_000_000,
    parameter int unsigned           BAUD        = 9600,
    parameter int unsigned           KEY_LEN     = 4,
    parameter logic [KEY_LEN*8-1:0]  KEY         = 32'h44434241,
    parameter int unsigned           MAX_TRIES   = 3,
    parameter int unsigned           HOLD_CYCLES = 1_000_000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n,
    uart_key_checker_if.slave  bus
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned IW  = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam int unsigned HW  = $clog2(HOLD_CYCLES + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(KEY_LEN - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [3:0]    TRY_LIMIT = 4'(MAX_TRIES);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        CK_COLLECT,
        CK_GRANTED,
        CK_DENIED,
        CK_LOCKED
    } ck_state_e;

    // Receiver state
    logic            sync1_q;
    logic            sync2_q;
    logic            prev_q;
    rx_state_e       rx_st_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            ferr_q;

    // Checker state
    ck_state_e       ck_q;
    logic [IW-1:0]   idx_q;
    logic            mis_q;
    logic [HW-1:0]   hold_q;
    logic [3:0]      fail_q;
    logic            green_q;
    logic            red_q;
    logic            locked_q;

    logic            mis_d;
    logic [3:0]      fail_d;
    logic [7:0]      key_byte;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rx_st_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync1_q    <= bus.uart_rx;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
            unique case (rx_st_q)
                RX_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        rx_st_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    // Mid start bit: a line already back high was a glitch
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        rx_st_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            rx_st_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        rx_st_q <= RX_IDLE;
                        if (sync2_q) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    rx_st_q <= RX_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        key_byte = KEY[8*idx_q +: 8];
        mis_d    = mis_q | (rx_data_q != key_byte);
        fail_d   = fail_q + 4'd1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            ck_q     <= CK_COLLECT;
            idx_q    <= '0;
            mis_q    <= 1'b0;
            hold_q   <= '0;
            fail_q   <= '0;
            green_q  <= 1'b0;
            red_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            unique case (ck_q)
                CK_COLLECT: begin
                    if (rx_valid_q) begin
                        if (idx_q == IDX_LAST) begin
                            idx_q <= '0;
                            mis_q <= 1'b0;
                            if (!mis_d) begin
                                ck_q    <= CK_GRANTED;
                                green_q <= 1'b1;
                                red_q   <= 1'b0;
                            end else begin
                                fail_q  <= fail_d;
                                hold_q  <= '0;
                                green_q <= 1'b0;
                                red_q   <= 1'b1;
                                if (fail_d == TRY_LIMIT) begin
                                    ck_q     <= CK_LOCKED;
                                    locked_q <= 1'b1;
                                end else begin
                                    ck_q <= CK_DENIED;
                                end
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            mis_q <= mis_d;
                        end
                    end else if (ferr_q) begin
                        // A broken frame restarts key entry
                        idx_q <= '0;
                        mis_q <= 1'b0;
                    end
                end
                CK_GRANTED: begin
                    green_q <= 1'b1;
                    red_q   <= 1'b0;
                end
                CK_DENIED: begin
                    if (hold_q == HOLD_LAST) begin
                        ck_q   <= CK_COLLECT;
                        red_q  <= 1'b0;
                        hold_q <= '0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                CK_LOCKED: begin
                    locked_q <= 1'b1;
                    red_q    <= 1'b1;
                    green_q  <= 1'b0;
                end
                default: begin
                    ck_q <= CK_COLLECT;
                end
            endcase
        end
    end

    assign bus.led_green  = green_q;
    assign bus.led_red    = red_q;
    assign bus.locked     = locked_q;
    assign bus.fail_count = fail_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;

endmodule

// File: tb/tb_uart_key_checker.sv
// Randomized bench for uart_key_checker against a byte-level
// reference model of key entry, retries and lockout.
module tb_uart_key_checker;

    localparam int DIV  = 10;
    localparam int HOLD = 50;
    localparam int MAXT = 3;
    localparam int KLEN = 4;
    localparam logic [31:0] KEYV = 32'h44434241;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_key_checker_if ifc();

    uart_key_checker #(
        .CLK_HZ      (10_000_000),
        .BAUD        (1_000_000),
        .KEY_LEN     (4),
        .KEY         (32'h44434241),
        .MAX_TRIES   (3),
        .HOLD_CYCLES (50)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .bus      (ifc)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: strobes, red run lengths, LED exclusivity
    logic [7:0] rxq[$];
    int red_run = 0;
    int last_red_len = -1;
    bit both_seen = 0;
    bit long_strobe = 0;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (rst_n && ifc.rx_valid === 1'b1) rxq.push_back(ifc.rx_data);
        if (ifc.rx_valid === 1'b1 && prev_valid === 1'b1) long_strobe = 1;
        prev_valid = ifc.rx_valid;
        if (ifc.led_green === 1'b1 && ifc.led_red === 1'b1) both_seen = 1;
        if (ifc.led_red === 1'b1) red_run++;
        else begin
            if (red_run > 0) last_red_len = red_run;
            red_run = 0;
        end
    end

    // Reference model: attempt-level bookkeeping
    logic [7:0] key_b[KLEN];
    logic [7:0] m_buf[$];
    bit m_green, m_locked, m_deny;
    int m_fails;

    function automatic void m_reset();
        m_buf.delete();
        m_green = 0;
        m_locked = 0;
        m_deny = 0;
        m_fails = 0;
    endfunction

    function automatic void m_byte(input logic [7:0] b);
        bit ok;
        if (m_green || m_locked || m_deny) return;
        m_buf.push_back(b);
        if (m_buf.size() == KLEN) begin
            ok = 1;
            for (int i = 0; i < KLEN; i++)
                if (m_buf[i] != key_b[i]) ok = 0;
            m_buf.delete();
            if (ok) m_green = 1;
            else begin
                m_fails++;
                if (m_fails == MAXT) m_locked = 1;
                else m_deny = 1;
            end
        end
    endfunction

    task automatic check_outputs(input string ctx);
        check({ctx, ".green"}, ifc.led_green, m_green);
        check({ctx, ".red"}, ifc.led_red, m_locked || m_deny);
        check({ctx, ".locked"}, ifc.locked, m_locked);
        check({ctx, ".fails"}, ifc.fail_count, m_fails);
    endtask

    task automatic wait_hold();
        int n = 0;
        while (ifc.led_red === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("hold_timeout", ifc.led_red, 0);
        check("hold_len", last_red_len, HOLD);
        m_deny = 0;
        check_outputs("post_hold");
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            ifc.uart_rx = fr[i];
            repeat (DIV) @(negedge clk);
        end
        ifc.uart_rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] b, input bit stop_ok);
        rxq.delete();
        send_frame(b, stop_ok);
        if (stop_ok) begin
            check("strobe_cnt", rxq.size(), 1);
            if (rxq.size() > 0) check("rx_data", rxq[0], b);
            m_byte(b);
        end else begin
            check("ferr_nostrobe", rxq.size(), 0);
            m_buf.delete();
        end
        check_outputs("byte");
        if (m_deny) wait_hold();
    endtask

    task automatic send_key(input logic [31:0] k);
        for (int i = 0; i < KLEN; i++) xfer(k[8*i +: 8], 1'b1);
    endtask

    task automatic glitch(input int len);
        rxq.delete();
        ifc.uart_rx = 1'b0;
        repeat (len) @(negedge clk);
        ifc.uart_rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check("glitch_nostrobe", rxq.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifc.uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        rxq.delete();
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] wrong_key();
        logic [31:0] k;
        k = $urandom;
        if (k == KEYV) k = k ^ 32'h1;
        return k;
    endfunction

    task automatic check_zero(input string ctx);
        check({ctx, ".green"}, ifc.led_green, 0);
        check({ctx, ".red"}, ifc.led_red, 0);
        check({ctx, ".locked"}, ifc.locked, 0);
        check({ctx, ".fails"}, ifc.fail_count, 0);
        check({ctx, ".rx_data"}, ifc.rx_data, 0);
        check({ctx, ".rx_valid"}, ifc.rx_valid, 0);
    endtask

    initial begin
        logic [7:0] b;
        int nops, r;
        for (int i = 0; i < KLEN; i++) key_b[i] = KEYV[8*i +: 8];
        ifc.uart_rx = 1'b1;
        m_reset();
        repeat (3) @(negedge clk);
        check_zero("in_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("post_reset");

        // Correct key
        send_key(KEYV);

        // One wrong key, hold, then correct
        do_reset();
        send_key(32'h45434241);
        send_key(KEYV);

        // Lockout after three wrong keys
        do_reset();
        for (int a = 0; a < MAXT; a++) send_key(wrong_key());
        send_key(KEYV);

        // Glitch rejection
        do_reset();
        glitch(3);
        send_key(KEYV);

        // Framing error restarts entry
        do_reset();
        xfer(8'h41, 1'b1);
        xfer(8'h42, 1'b1);
        xfer(8'h43, 1'b0);
        send_key(KEYV);

        // Reset in the middle of the third byte after a failure
        do_reset();
        send_key(wrong_key());
        xfer(8'h41, 1'b1);
        xfer(8'h42, 1'b1);
        ifc.uart_rx = 1'b0;
        repeat (DIV + DIV / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        ifc.uart_rx = 1'b1;
        check_zero("midframe_rst");
        rst_n = 1'b1;
        m_reset();
        rxq.delete();
        repeat (2 * DIV) @(negedge clk);
        check("midframe_nostrobe", rxq.size(), 0);
        send_key(KEYV);

        // Random mixed traffic
        for (int it = 0; it < 6; it++) begin
            do_reset();
            nops = $urandom_range(4, 14);
            for (int o = 0; o < nops; o++) begin
                r = $urandom_range(0, 9);
                if (r < 5) begin
                    b = key_b[m_buf.size() % KLEN];
                    xfer(b, 1'b1);
                end else if (r < 8) begin
                    b = 8'($urandom);
                    xfer(b, 1'b1);
                end else if (r == 8) begin
                    b = 8'($urandom);
                    xfer(b, 1'b0);
                end else begin
                    glitch($urandom_range(1, 4));
                end
            end
        end

        check("leds_exclusive", both_seen, 0);
        check("strobe_1cyc", long_strobe, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
